fifo_bram_sync: RTL

//  Synchronous single-clock FIFO on an inferred simple-dual-port block RAM. Parametrised

---
 rtl/fifo_pkg.sv | 41 ++++
 rtl/bram_sdp.sv | 42 ++++
 rtl/fifo_bram_sync.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family.
//   MODE_STD / MODE_FWFT : read-mode selectors
//   out_state_e          : state of the FWFT output stage
//   clog2                : ceiling log2 for sizing
//   ptr_full / ptr_empty : compare two wrap-bit binary pointers (zero-extended to 32 bits)
package fifo_pkg;

    localparam logic MODE_STD  = 1'b0;
    localparam logic MODE_FWFT = 1'b1;

    typedef enum logic [1:0] {
        OUT_IDLE  = 2'd0,
        OUT_PEND  = 2'd1,
        OUT_VALID = 2'd2
    } out_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Full when only the wrap bit (bit addr_w) differs.
    function automatic logic ptr_full(input logic [31:0] wr_ptr,
                                      input logic [31:0] rd_ptr,
                                      input int          addr_w);
        return (wr_ptr ^ rd_ptr) == (32'd1 << addr_w);
    endfunction

    function automatic logic ptr_empty(input logic [31:0] wr_ptr,
                                       input logic [31:0] rd_ptr);
        return wr_ptr == rd_ptr;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM, written in a form that maps onto block RAM.
//   clk     : clock
//   reset   : async active-high, clears only the read data register
//   we_a    : port A write enable
//   addr_a  : port A write address
//   din_a   : port A write data
//   en_b    : port B read enable
//   addr_b  : port B read address, captured on the clock edge
//   dout_b  : port B read data, one clock after en_b, held until the next en_b
module bram_sdp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    input  logic              en_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] dout_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
    end

    // Read data is registered rather than decoded from a held address, so the
    // word stays stable even after its slot is freed and rewritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_b <= '0;
        end else if (en_b) begin
            dout_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/fifo_bram_sync.sv
// Single-clock FIFO on a block RAM, standard or first-word-fall-through read.
//   clk          : clock
//   reset        : async active-high reset, discards all contents
//   wr_en        : write request, accepted when !full
//   wr_data      : write data
//   full         : RAM holds DEPTH words
//   almost_full  : level >= AFULL_LVL
//   overflow     : one-clock pulse after a write request while full
//   rd_en        : read request (FWFT: pop of rd_data), accepted when !empty
//   rd_data      : read data
//   empty        : nothing to read (FWFT: rd_data not valid)
//   almost_empty : level <= AEMPTY_LVL
//   underflow    : one-clock pulse after a read request while empty
//   level        : words held, including the FWFT output register
//
// FWFT output stage (rd_data is the RAM read register in both modes):
//   state     | meaning
//   OUT_IDLE  | read register holds no live word
//   OUT_PEND  | word fetched into read register, not yet presented
//   OUT_VALID | rd_data valid, empty low, rd_en pops it
module fifo_bram_sync
    import fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int FWFT       = 0,
    parameter int AFULL_LVL  = 2**ADDR_W - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              almost_empty,
    output logic              underflow,
    output logic [ADDR_W:0]   level
);

    localparam logic            MODE     = (FWFT != 0) ? MODE_FWFT : MODE_STD;
    localparam logic [ADDR_W:0] AFULL_T  = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] AEMPTY_T = (ADDR_W+1)'(AEMPTY_LVL);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] wr_ptr_n;
    logic [ADDR_W:0] rd_ptr_n;
    logic [ADDR_W:0] level_n;
    logic            ram_empty;
    logic            ram_empty_n;
    logic            ram_full_n;
    logic            empty_n;
    logic            hold_n;
    logic            wr_acc;
    logic            rd_acc;
    logic            ram_rd;
    out_state_e      out_state;
    out_state_e      out_state_n;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    bram_sdp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we_a   (wr_acc),
        .addr_a (wr_ptr[ADDR_W-1:0]),
        .din_a  (wr_data),
        .en_b   (ram_rd),
        .addr_b (rd_ptr[ADDR_W-1:0]),
        .dout_b (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_state <= OUT_IDLE;
        end else begin
            out_state <= out_state_n;
        end
    end

    // In standard mode the RAM is read directly on each accepted read.
    // In FWFT mode the read register is refilled whenever it is empty or
    // being popped; a fetch into an idle stage waits one clock in OUT_PEND,
    // so a word written into an empty FIFO shows up two clocks after its write.
    always_comb begin
        out_state_n = out_state;
        ram_rd      = 1'b0;
        if (MODE == MODE_STD) begin
            ram_rd = rd_acc;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (!ram_empty) begin
                        ram_rd      = 1'b1;
                        out_state_n = OUT_PEND;
                    end
                end
                OUT_PEND: begin
                    out_state_n = OUT_VALID;
                end
                OUT_VALID: begin
                    if (rd_acc) begin
                        if (!ram_empty) begin
                            ram_rd = 1'b1;
                        end else begin
                            out_state_n = OUT_IDLE;
                        end
                    end
                end
                default: begin
                    out_state_n = OUT_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_n    = wr_ptr + {{ADDR_W{1'b0}}, wr_acc};
        rd_ptr_n    = rd_ptr + {{ADDR_W{1'b0}}, ram_rd};
        hold_n      = (MODE == MODE_FWFT) && (out_state_n != OUT_IDLE);
        level_n     = (wr_ptr_n - rd_ptr_n) + {{ADDR_W{1'b0}}, hold_n};
        ram_empty_n = ptr_empty(32'(wr_ptr_n), 32'(rd_ptr_n));
        ram_full_n  = ptr_full(32'(wr_ptr_n), 32'(rd_ptr_n), ADDR_W);
        empty_n     = (MODE == MODE_STD) ? ram_empty_n : (out_state_n != OUT_VALID);
    end

    // Flags are registered from next-state values so they change on the same
    // edge as the pointers and never combinationally follow wr_en/rd_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            ram_empty    <= 1'b1;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            level        <= level_n;
            ram_empty    <= ram_empty_n;
            empty        <= empty_n;
            almost_empty <= (level_n <= AEMPTY_T);
            full         <= ram_full_n;
            almost_full  <= (level_n >= AFULL_T);
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
        end
    end

endmodule
